// File: rtl/packet_rr_arbiter_if.sv
// Flit types shared with the router, plus the bundle of request, flit and status
// signals between the requesters/downstream port and packet_rr_arbiter.
package router_pkg;
    typedef enum logic [1:0] {
        NONE_FLIT = 2'd0,
        HEAD_FLIT = 2'd1,
        BODY_FLIT = 2'd2,
        TAIL_FLIT = 2'd3
    } flit_type_e;

    typedef struct packed {
        logic       valid;
        flit_type_e flit_type;
        logic [15:0] data;
    } FLIT_t;
endpackage

interface packet_rr_arbiter_if
    import router_pkg::*;
#(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]  i_req;
    FLIT_t [NUM_REQ-1:0] i_flit;
    logic                i_ready;
    logic [NUM_REQ-1:0]  o_grant;
    FLIT_t               o_flit;
    logic                o_flit_valid;
    logic                o_busy;
    logic [15:0]         o_pkt_count;
    logic                o_proto_err;
    logic                o_timeout;

    modport master (
        output i_req, i_flit, i_ready,
        input  o_grant, o_flit, o_flit_valid, o_busy, o_pkt_count, o_proto_err, o_timeout
    );

    modport slave (
        input  i_req, i_flit, i_ready,
        output o_grant, o_flit, o_flit_valid, o_busy, o_pkt_count, o_proto_err, o_timeout
    );
endinterface

// File: rtl/packet_rr_arbiter.sv
// Round-robin packet arbiter: grants one requester per packet and forwards its flits.
// Optional grant timeout is built only when ARB_TIMEOUT_EN is defined.
module packet_rr_arbiter
    import router_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               reset,
    packet_rr_arbiter_if.slave bus
);
    // state   | meaning
    // IDLE    | no grant, waiting for a request while downstream is ready
    // XFER    | grant held on last_q, forwarding its flits until tail
    // RELEASE | one-cycle gap after tail/timeout before arbitrating again
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        XFER    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("packet_rr_arbiter: parameter out of range");
    end

    state_t           state_q, state_d;
    logic [IDX_W-1:0] last_q, sel_idx, cand;
    logic             found;
    FLIT_t            cur_flit;
    logic             start, fwd, fwd_tail, fwd_bad, timeout_hit;
    logic             seen_head_q;
    FLIT_t            flit_q;
    logic             flit_valid_q;
    logic [15:0]      pkt_count_q;
    logic             proto_err_q;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        sel_idx = last_q;
        cand    = '0;
        found   = 1'b0;
        // last_q doubles as the current grant index while in XFER
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((32'(last_q) + 32'(k)) % NUM_REQ);
            if (!found && bus.i_req[cand]) begin
                sel_idx = cand;
                found   = 1'b1;
            end
        end

        cur_flit = bus.i_flit[last_q];
        start    = (state_q == IDLE) && (|bus.i_req) && bus.i_ready;
        fwd      = (state_q == XFER) && cur_flit.valid;
        fwd_tail = fwd && (cur_flit.flit_type == TAIL_FLIT);
        fwd_bad  = fwd && (seen_head_q ? (cur_flit.flit_type == HEAD_FLIT)
                                       : (cur_flit.flit_type != HEAD_FLIT));

        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = XFER;
            XFER:    if (fwd_tail || timeout_hit) state_d = RELEASE;
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q       <= IDX_W'(NUM_REQ - 1);
            seen_head_q  <= 1'b0;
            flit_q       <= '0;
            flit_valid_q <= 1'b0;
            pkt_count_q  <= '0;
            proto_err_q  <= 1'b0;
        end else begin
            flit_valid_q <= fwd;
            if (fwd) flit_q <= cur_flit;

            if (start) begin
                last_q      <= sel_idx;
                seen_head_q <= 1'b0;
            end else if (fwd && cur_flit.flit_type == HEAD_FLIT) begin
                seen_head_q <= 1'b1;
            end

            if (fwd_tail) pkt_count_q <= pkt_count_q + 16'd1;
            if (fwd_bad || timeout_hit) proto_err_q <= 1'b1;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMR_W-1:0] tmr_q;
    logic             timeout_q;

    // Down-counter reloads on grant and on every forwarded flit; expiry fires at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmr_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_hit;
            if (start || fwd)
                tmr_q <= TMR_W'(TIMEOUT_CYCLES - 1);
            else if (state_q == XFER && tmr_q != '0)
                tmr_q <= tmr_q - TMR_W'(1);
        end
    end

    assign timeout_hit   = (state_q == XFER) && !fwd && (tmr_q == '0);
    assign bus.o_timeout = timeout_q;
`else
    assign timeout_hit   = 1'b0;
    assign bus.o_timeout = 1'b0;
`endif

    assign bus.o_grant      = (state_q == XFER) ? (NUM_REQ'(1) << last_q) : '0;
    assign bus.o_busy       = (state_q == XFER);
    assign bus.o_flit       = flit_q;
    assign bus.o_flit_valid = flit_valid_q;
    assign bus.o_pkt_count  = pkt_count_q;
    assign bus.o_proto_err  = proto_err_q;
endmodule

// File: tb/tb_packet_rr_arbiter.sv
// Directed bench for packet_rr_arbiter with hand-computed expectations.
module tb_packet_rr_arbiter;
    import router_pkg::*;

    localparam int NUM_REQ        = 4;
    localparam int TIMEOUT_CYCLES = 8;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    packet_rr_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    packet_rr_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic FLIT_t mk(input flit_type_e t, input logic [15:0] d);
        FLIT_t f;
        f.valid     = 1'b1;
        f.flit_type = t;
        f.data      = d;
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_req   = '0;
        bus.i_ready = 1'b1;
        bus.i_flit  = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bus.i_req     = 4'b1111;
        bus.i_ready   = 1'b1;
        bus.i_flit[0] = mk(HEAD_FLIT, 16'h1234);
        reset = 1'b1;
        tick();
        tick();
        checks++; if (bus.o_grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b exp 0000", bus.o_grant); end
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.o_busy); end
        checks++; if (bus.o_flit_valid !== 1'b0) begin errors++; $display("FAIL reset_flit_valid got %b exp 0", bus.o_flit_valid); end
        checks++; if (bus.o_flit !== FLIT_t'(0)) begin errors++; $display("FAIL reset_flit got %h exp 0", bus.o_flit); end
        checks++; if (bus.o_pkt_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.o_pkt_count); end
        checks++; if (bus.o_proto_err !== 1'b0) begin errors++; $display("FAIL reset_proto_err got %b exp 0", bus.o_proto_err); end
        checks++; if (bus.o_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b exp 0", bus.o_timeout); end
        reset = 1'b0;
        idle_inputs();
    endtask

    task automatic test_single();
        do_reset();
        bus.i_req = 4'b0001;
        tick();
        checks++; if (bus.o_grant !== 4'b0001) begin errors++; $display("FAIL single_grant got %b exp 0001", bus.o_grant); end
        checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", bus.o_busy); end
        checks++; if (bus.o_flit_valid !== 1'b0) begin errors++; $display("FAIL single_grant_fv got %b exp 0", bus.o_flit_valid); end
        bus.i_req     = 4'b1110;
        bus.i_flit[0] = mk(HEAD_FLIT, 16'hA000);
        bus.i_flit[1] = mk(HEAD_FLIT, 16'hBAD1);
        tick();
        checks++; if (bus.o_flit_valid !== 1'b1 || bus.o_flit !== mk(HEAD_FLIT, 16'hA000)) begin errors++; $display("FAIL single_head got %b/%h exp 1/%h", bus.o_flit_valid, bus.o_flit, mk(HEAD_FLIT, 16'hA000)); end
        checks++; if (bus.o_grant !== 4'b0001) begin errors++; $display("FAIL single_grant_held got %b exp 0001", bus.o_grant); end
        bus.i_flit[0] = '0;
        tick();
        checks++; if (bus.o_flit_valid !== 1'b0) begin errors++; $display("FAIL single_invalid_ignored got %b exp 0", bus.o_flit_valid); end
        bus.i_flit[0] = mk(BODY_FLIT, 16'hA001);
        tick();
        checks++; if (bus.o_flit_valid !== 1'b1 || bus.o_flit !== mk(BODY_FLIT, 16'hA001)) begin errors++; $display("FAIL single_body got %b/%h exp 1/%h", bus.o_flit_valid, bus.o_flit, mk(BODY_FLIT, 16'hA001)); end
        bus.i_flit[0] = mk(TAIL_FLIT, 16'hA002);
        tick();
        checks++; if (bus.o_flit_valid !== 1'b1 || bus.o_flit !== mk(TAIL_FLIT, 16'hA002)) begin errors++; $display("FAIL single_tail got %b/%h exp 1/%h", bus.o_flit_valid, bus.o_flit, mk(TAIL_FLIT, 16'hA002)); end
        checks++; if (bus.o_grant !== 4'b0000 || bus.o_busy !== 1'b0) begin errors++; $display("FAIL single_release got grant %b busy %b exp 0000 0", bus.o_grant, bus.o_busy); end
        checks++; if (bus.o_pkt_count !== 16'd1) begin errors++; $display("FAIL single_count got %0d exp 1", bus.o_pkt_count); end
        idle_inputs();
        tick();
        checks++; if (bus.o_flit_valid !== 1'b0 || bus.o_grant !== 4'b0000) begin errors++; $display("FAIL single_idle got fv %b grant %b exp 0 0000", bus.o_flit_valid, bus.o_grant); end
    endtask

    task automatic test_rr();
        int         g;
        logic [3:0] eg;
        do_reset();
        bus.i_req = 4'b1111;
        for (int r = 0; r < NUM_REQ; r++) bus.i_flit[r] = mk(BODY_FLIT, 16'(16'hD000 + r));
        for (int p = 0; p < 5; p++) begin
            g  = p % NUM_REQ;
            eg = 4'b0001 << g;
            tick();
            checks++; if (bus.o_grant !== eg || bus.o_busy !== 1'b1) begin errors++; $display("FAIL rr_grant pkt %0d got %b exp %b", p, bus.o_grant, eg); end
            bus.i_flit[g] = mk(HEAD_FLIT, 16'(16'h100 * p));
            tick();
            checks++; if (bus.o_flit !== mk(HEAD_FLIT, 16'(16'h100 * p))) begin errors++; $display("FAIL rr_head pkt %0d got %h exp %h", p, bus.o_flit, mk(HEAD_FLIT, 16'(16'h100 * p))); end
            bus.i_flit[g] = mk(BODY_FLIT, 16'(16'h100 * p + 1));
            tick();
            checks++; if (bus.o_flit !== mk(BODY_FLIT, 16'(16'h100 * p + 1))) begin errors++; $display("FAIL rr_body pkt %0d got %h exp %h", p, bus.o_flit, mk(BODY_FLIT, 16'(16'h100 * p + 1))); end
            bus.i_flit[g] = mk(TAIL_FLIT, 16'(16'h100 * p + 2));
            tick();
            checks++; if (bus.o_flit !== mk(TAIL_FLIT, 16'(16'h100 * p + 2)) || bus.o_grant !== 4'b0000 || bus.o_busy !== 1'b0) begin errors++; $display("FAIL rr_tail pkt %0d got %h grant %b busy %b", p, bus.o_flit, bus.o_grant, bus.o_busy); end
            bus.i_flit[g] = mk(BODY_FLIT, 16'(16'hD000 + g));
            tick();
            checks++; if (bus.o_grant !== 4'b0000 || bus.o_flit_valid !== 1'b0) begin errors++; $display("FAIL rr_gap pkt %0d got grant %b fv %b exp 0000 0", p, bus.o_grant, bus.o_flit_valid); end
        end
        checks++; if (bus.o_pkt_count !== 16'd5) begin errors++; $display("FAIL rr_count got %0d exp 5", bus.o_pkt_count); end
        idle_inputs();
    endtask

    task automatic test_not_ready();
        bus.i_ready = 1'b0;
        bus.i_req   = 4'b0100;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++; if (bus.o_grant !== 4'b0000 || bus.o_busy !== 1'b0) begin errors++; $display("FAIL notready_hold cycle %0d got grant %b busy %b", k, bus.o_grant, bus.o_busy); end
        end
        bus.i_ready = 1'b1;
        tick();
        checks++; if (bus.o_grant !== 4'b0100) begin errors++; $display("FAIL notready_grant got %b exp 0100", bus.o_grant); end
        bus.i_req     = '0;
        bus.i_flit[2] = mk(HEAD_FLIT, 16'h0C00);
        tick();
        bus.i_flit[2] = mk(TAIL_FLIT, 16'h0C01);
        tick();
        checks++; if (bus.o_pkt_count !== 16'd6) begin errors++; $display("FAIL notready_count got %0d exp 6", bus.o_pkt_count); end
        idle_inputs();
        tick();
    endtask

    task automatic test_proto_err();
        do_reset();
        checks++; if (bus.o_proto_err !== 1'b0) begin errors++; $display("FAIL proto_clear got %b exp 0", bus.o_proto_err); end
        bus.i_req = 4'b0001;
        tick();
        bus.i_req     = '0;
        bus.i_flit[0] = mk(BODY_FLIT, 16'hE001);
        tick();
        checks++; if (bus.o_proto_err !== 1'b1) begin errors++; $display("FAIL proto_body_first got %b exp 1", bus.o_proto_err); end
        checks++; if (bus.o_flit_valid !== 1'b1 || bus.o_flit !== mk(BODY_FLIT, 16'hE001)) begin errors++; $display("FAIL proto_still_fwd got %b/%h exp 1/%h", bus.o_flit_valid, bus.o_flit, mk(BODY_FLIT, 16'hE001)); end
        bus.i_flit[0] = mk(TAIL_FLIT, 16'hE002);
        tick();
        idle_inputs();
        tick();
        bus.i_req = 4'b0010;
        tick();
        checks++; if (bus.o_grant !== 4'b0010) begin errors++; $display("FAIL proto_next_grant got %b exp 0010", bus.o_grant); end
        bus.i_req     = '0;
        bus.i_flit[1] = mk(HEAD_FLIT, 16'hE100);
        tick();
        bus.i_flit[1] = mk(TAIL_FLIT, 16'hE101);
        tick();
        checks++; if (bus.o_proto_err !== 1'b1 || bus.o_pkt_count !== 16'd2) begin errors++; $display("FAIL proto_sticky got err %b count %0d exp 1 2", bus.o_proto_err, bus.o_pkt_count); end
        idle_inputs();
        tick();
        do_reset();
        checks++; if (bus.o_proto_err !== 1'b0) begin errors++; $display("FAIL proto_reset got %b exp 0", bus.o_proto_err); end
        bus.i_req = 4'b0001;
        tick();
        bus.i_req     = '0;
        bus.i_flit[0] = mk(HEAD_FLIT, 16'hF000);
        tick();
        checks++; if (bus.o_proto_err !== 1'b0) begin errors++; $display("FAIL proto_good_head got %b exp 0", bus.o_proto_err); end
        bus.i_flit[0] = mk(HEAD_FLIT, 16'hF001);
        tick();
        checks++; if (bus.o_proto_err !== 1'b1 || bus.o_flit !== mk(HEAD_FLIT, 16'hF001)) begin errors++; $display("FAIL proto_double_head got err %b flit %h", bus.o_proto_err, bus.o_flit); end
        bus.i_flit[0] = mk(TAIL_FLIT, 16'hF002);
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.i_req = 4'b0011;
        tick();
        checks++; if (bus.o_grant !== 4'b0001) begin errors++; $display("FAIL midrst_first_grant got %b exp 0001", bus.o_grant); end
        bus.i_flit[0] = mk(HEAD_FLIT, 16'h7700);
        tick();
        checks++; if (bus.o_flit_valid !== 1'b1) begin errors++; $display("FAIL midrst_head got %b exp 1", bus.o_flit_valid); end
        reset = 1'b1;
        bus.i_flit[0] = mk(TAIL_FLIT, 16'h7701);
        tick();
        checks++; if (bus.o_grant !== 4'b0000 || bus.o_busy !== 1'b0 || bus.o_flit_valid !== 1'b0 || bus.o_flit !== FLIT_t'(0)) begin errors++; $display("FAIL midrst_outputs got grant %b busy %b fv %b flit %h", bus.o_grant, bus.o_busy, bus.o_flit_valid, bus.o_flit); end
        checks++; if (bus.o_pkt_count !== 16'd0 || bus.o_proto_err !== 1'b0) begin errors++; $display("FAIL midrst_count got count %0d err %b exp 0 0", bus.o_pkt_count, bus.o_proto_err); end
        reset = 1'b0;
        bus.i_flit = '0;
        tick();
        checks++; if (bus.o_grant !== 4'b0001 || bus.o_flit_valid !== 1'b0) begin errors++; $display("FAIL midrst_regrant got grant %b fv %b exp 0001 0", bus.o_grant, bus.o_flit_valid); end
        bus.i_req     = '0;
        bus.i_flit[0] = mk(HEAD_FLIT, 16'h7800);
        tick();
        bus.i_flit[0] = mk(TAIL_FLIT, 16'h7801);
        tick();
        checks++; if (bus.o_pkt_count !== 16'd1) begin errors++; $display("FAIL midrst_after_count got %0d exp 1", bus.o_pkt_count); end
        idle_inputs();
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        bus.i_req = 4'b0001;
        tick();
        bus.i_req     = '0;
        bus.i_flit[0] = mk(HEAD_FLIT, 16'h5500);
        tick();
        bus.i_flit[0] = '0;
`ifdef ARB_TIMEOUT_EN
        begin
            int seen;
            seen = -1;
            for (int k = 1; k <= 3 * TIMEOUT_CYCLES && seen < 0; k++) begin
                tick();
                if (bus.o_timeout === 1'b1) seen = k;
            end
            checks++; if (seen != TIMEOUT_CYCLES) begin errors++; $display("FAIL timeout_delay got %0d exp %0d", seen, TIMEOUT_CYCLES); end
            checks++; if (bus.o_grant !== 4'b0000 || bus.o_busy !== 1'b0) begin errors++; $display("FAIL timeout_release got grant %b busy %b", bus.o_grant, bus.o_busy); end
            checks++; if (bus.o_pkt_count !== 16'd0 || bus.o_proto_err !== 1'b1) begin errors++; $display("FAIL timeout_status got count %0d err %b exp 0 1", bus.o_pkt_count, bus.o_proto_err); end
            tick();
            checks++; if (bus.o_timeout !== 1'b0) begin errors++; $display("FAIL timeout_pulse got %b exp 0", bus.o_timeout); end
        end
`else
        for (int k = 0; k < 30; k++) begin
            tick();
            checks++; if (bus.o_timeout !== 1'b0 || bus.o_grant !== 4'b0001) begin errors++; $display("FAIL notimeout_hold cycle %0d got to %b grant %b", k, bus.o_timeout, bus.o_grant); end
        end
        bus.i_flit[0] = mk(TAIL_FLIT, 16'h5501);
        tick();
        checks++; if (bus.o_pkt_count !== 16'd1 || bus.o_proto_err !== 1'b0) begin errors++; $display("FAIL notimeout_tail got count %0d err %b exp 1 0", bus.o_pkt_count, bus.o_proto_err); end
`endif
        idle_inputs();
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_single();
        test_rr();
        test_not_ready();
        test_proto_err();
        test_reset_mid();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/packet_rr_arbiter.md
PACKET_RR_ARBITER -- requirements
Module: packet_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning number of traffic requesters sharing one router input port (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning max cycles a grant is held without a tail flit (used only under ARB_TIMEOUT_EN).
REQ-003 SHALL have port clk  input  1  rising-edge clock; one clock only.
REQ-004 SHALL have port reset  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port i_req  input  NUM_REQ  per-requester "complete packet buffered, request to send".
REQ-006 SHALL have port i_flit  input  NUM_REQ x FLIT_SIZE (FLIT_t from router_pkg)  per-requester flit; flit.valid marks a live flit.
REQ-007 SHALL have port i_ready  input  1  downstream port can accept a whole packet.
REQ-008 SHALL have port o_grant  output  NUM_REQ  one-hot send permission to the selected requester.
REQ-009 SHALL have port o_flit  output  FLIT_SIZE  registered forwarded flit.
REQ-010 SHALL have port o_flit_valid  output  1  o_flit is live this cycle.
REQ-011 SHALL have port o_busy  output  1  a packet grant is in progress.
REQ-012 SHALL have port o_pkt_count  output  16  count of tail flits forwarded.
REQ-013 SHALL have port o_proto_err  output  1  sticky protocol-error flag.
REQ-014 SHALL have port o_timeout  output  1  one-cycle pulse on grant timeout (tied 0 without ARB_TIMEOUT_EN).

Function
REQ-015 SHALL implement FSM IDLE -> XFER -> RELEASE -> IDLE.
REQ-016 IDLE: if |i_req and i_ready at edge N, SHALL enter XFER with o_grant one-hot and o_busy=1 from edge N; otherwise stay IDLE with o_grant=0.
REQ-017 Selection SHALL be round-robin: search starts at (last_granted+1) mod NUM_REQ; last_granted updates on each grant.
REQ-018 XFER: o_grant SHALL be held constant regardless of i_req changes until the tail is forwarded.
REQ-019 XFER: each cycle a flit from the granted requester has valid=1, it SHALL appear on o_flit with o_flit_valid=1 exactly one cycle later; flits with valid=0 and flits from non-granted requesters SHALL be ignored.
REQ-020 A forwarded flit with flit_type==TAIL_FLIT SHALL move the FSM to RELEASE at the same edge, clearing o_grant and incrementing o_pkt_count (wraps 0xFFFF->0).
REQ-021 RELEASE SHALL last exactly one cycle with o_grant=0, o_busy=0, then return to IDLE; minimum inter-packet gap is therefore one cycle.
REQ-022 Per packet, the first forwarded flit SHALL be HEAD_FLIT; BODY/TAIL before HEAD, or a second HEAD before TAIL, SHALL set o_proto_err (stays set until reset) and the flit SHALL still be forwarded.
REQ-023 o_flit_valid SHALL be 0 in IDLE and RELEASE except for the final forwarded flit registered at the tail edge.
REQ-024 With NUM_REQ requesters all continuously requesting, each SHALL be granted once per NUM_REQ packets.

Reset
REQ-025 On reset high at a clock edge: state=IDLE, o_grant=0, o_flit=0, o_flit_valid=0, o_busy=0, o_pkt_count=0, o_proto_err=0, o_timeout=0, last_granted=NUM_REQ-1 (requester 0 wins first).
REQ-026 Reset asserted mid-packet SHALL abandon the packet with no further flits forwarded and no count increment.

Configuration
REQ-027 Macro ARB_TIMEOUT_EN SHALL, when defined, add a cycle counter that clears on grant and on each forwarded flit; reaching TIMEOUT_CYCLES in XFER SHALL force RELEASE, pulse o_timeout for one cycle, set o_proto_err, and not increment o_pkt_count.
REQ-028 Without ARB_TIMEOUT_EN, no counter SHALL be built, o_timeout SHALL be constant 0, and a grant SHALL be held indefinitely until a tail.

Verification
REQ-029 Reset, then i_req=4'b0001, i_ready=1, requester 0 sends HEAD,BODY,TAIL -> o_grant=0001 one cycle after request; three flits on o_flit, each delayed 1 cycle; o_pkt_count=1; o_grant=0 after tail.
REQ-030 i_req=4'b1111 held, each packet 3 flits -> grant order 0,1,2,3,0; one RELEASE cycle between packets; o_pkt_count=5.
REQ-031 i_ready=0 with i_req=4'b0100 for 10 cycles -> o_grant stays 0; i_ready=1 -> o_grant=0100 next edge.
REQ-032 Requester sends BODY first -> o_proto_err=1 and remains 1 after later valid packets until reset.
REQ-033 Reset pulsed after HEAD of a granted packet -> all outputs 0 next cycle, o_pkt_count=0, next grant goes to requester 0.
REQ-034 With ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, granted requester sends HEAD then nothing -> o_timeout pulses 8 cycles after HEAD, grant drops, o_pkt_count unchanged.
